// File: rtl/multiplier_arbiter_pkg.sv
// Shared sizing defaults and operand/tag types for the multiplier arbiter and its tag FIFO.
package multiplier_arbiter_pkg;

  localparam int DEFAULT_NUM_REQUESTERS        = 4;
  localparam int DEFAULT_OPERAND_WIDTH_IN_BITS = 64;
  localparam int DEFAULT_PRODUCT_WIDTH_IN_BITS = 2 * DEFAULT_OPERAND_WIDTH_IN_BITS;
  localparam int DEFAULT_TAG_FIFO_DEPTH        = 4;

  typedef logic [$clog2(DEFAULT_NUM_REQUESTERS)-1:0] req_id_t;

  typedef struct packed {
    logic                                     multiplier_sign_bit;
    logic [DEFAULT_OPERAND_WIDTH_IN_BITS-1:0] multiplier;
    logic                                     multicand_sign_bit;
    logic [DEFAULT_OPERAND_WIDTH_IN_BITS-1:0] multicand;
  } issue_entry_t;

endpackage

// File: rtl/multiplier_tag_fifo.sv
// In-order requester-ID FIFO; pushes while full and pops while empty are ignored.
// Full/empty/count reflect occupancy before this cycle's push and pop.
module multiplier_tag_fifo
  import multiplier_arbiter_pkg::*;
#(
  parameter int WIDTH = $clog2(DEFAULT_NUM_REQUESTERS),
  parameter int DEPTH = DEFAULT_TAG_FIFO_DEPTH
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin share of one multiplier: grant -> issue slot -> multiplier, products return in order, registered, one cycle.
// Grants stall while the issue slot is busy or the tag FIFO is full; results have no backpressure. Option: MULTIPLIER_ARBITER_STATS_EN.
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS        = DEFAULT_NUM_REQUESTERS,
  parameter int OPERAND_WIDTH_IN_BITS = DEFAULT_OPERAND_WIDTH_IN_BITS,
  parameter int PRODUCT_WIDTH_IN_BITS = DEFAULT_PRODUCT_WIDTH_IN_BITS,
  parameter int TAG_FIFO_DEPTH        = DEFAULT_TAG_FIFO_DEPTH
) (
  input  logic                                              clk_in,
  input  logic                                              reset_in,
  input  logic [NUM_REQUESTERS-1:0]                         req_valid_in,
  output logic [NUM_REQUESTERS-1:0]                         req_ready_out,
  input  logic [NUM_REQUESTERS-1:0]                         req_multiplier_sign_bit_in,
  input  logic [NUM_REQUESTERS*OPERAND_WIDTH_IN_BITS-1:0]   req_multiplier_in,
  input  logic [NUM_REQUESTERS-1:0]                         req_multicand_sign_bit_in,
  input  logic [NUM_REQUESTERS*OPERAND_WIDTH_IN_BITS-1:0]   req_multicand_in,
  output logic [NUM_REQUESTERS-1:0]                         resp_valid_out,
  output logic                                              resp_product_sign_bit_out,
  output logic [PRODUCT_WIDTH_IN_BITS-1:0]                  resp_product_out,
  output logic                                              mul_is_valid_out,
  input  logic                                              mul_is_ready_in,
  output logic                                              mul_multiplier_sign_bit_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0]                  mul_multiplier_out,
  output logic                                              mul_multicand_sign_bit_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0]                  mul_multicand_out,
  input  logic                                              mul_is_valid_in,
  input  logic                                              mul_product_sign_bit_in,
  input  logic [PRODUCT_WIDTH_IN_BITS-1:0]                  mul_product_in,
  output logic                                              error_out
`ifdef MULTIPLIER_ARBITER_STATS_EN
  ,
  output logic [31:0]                                       stat_issued_out,
  output logic [31:0]                                       stat_stall_out
`endif
);

  localparam int N    = NUM_REQUESTERS;
  localparam int W    = OPERAND_WIDTH_IN_BITS;
  localparam int ID_W = $clog2(N);
  localparam int CW   = $clog2(TAG_FIFO_DEPTH) + 1;

  typedef logic [ID_W-1:0] id_t;
  typedef struct packed {
    logic         multiplier_sign_bit;
    logic [W-1:0] multiplier;
    logic         multicand_sign_bit;
    logic [W-1:0] multicand;
  } issue_t;

  issue_t          issue_q;
  issue_t          issue_d;
  logic            issue_valid;
  logic            mul_fire;
  logic            slot_free;
  logic            accept;
  logic            tag_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  id_t             last_grant;
  id_t             grant_id;
  id_t             cand;
  id_t             tag_head;
  logic [N-1:0]    grant;
  logic            grant_found;
  int              idx;

  assign mul_fire  = issue_valid & mul_is_ready_in;
  assign slot_free = ~issue_valid | mul_fire;

  // First valid requester after last_grant, wrapping modulo N.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    idx         = 0;
    cand        = '0;
    for (int i = 1; i <= N; i++) begin
      idx  = (int'(last_grant) + i) % N;
      cand = id_t'(idx);
      if (!grant_found && req_valid_in[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign req_ready_out = (slot_free && !fifo_full && !reset_in) ? grant : '0;
  assign accept        = |req_ready_out;
  assign tag_pop       = mul_is_valid_in & ~fifo_empty;

  always_comb begin
    issue_d                     = '0;
    issue_d.multiplier_sign_bit = req_multiplier_sign_bit_in[grant_id];
    issue_d.multiplier          = req_multiplier_in[grant_id*W +: W];
    issue_d.multicand_sign_bit  = req_multicand_sign_bit_in[grant_id];
    issue_d.multicand           = req_multicand_in[grant_id*W +: W];
  end

  assign mul_is_valid_out            = issue_valid;
  assign mul_multiplier_sign_bit_out = issue_q.multiplier_sign_bit;
  assign mul_multiplier_out          = issue_q.multiplier;
  assign mul_multicand_sign_bit_out  = issue_q.multicand_sign_bit;
  assign mul_multicand_out           = issue_q.multicand;

  multiplier_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (TAG_FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .push     (accept),
    .pop      (tag_pop),
    .data_in  (grant_id),
    .data_out (tag_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      issue_q                   <= '0;
      issue_valid               <= 1'b0;
      last_grant                <= id_t'(N - 1);
      resp_valid_out            <= '0;
      resp_product_sign_bit_out <= 1'b0;
      resp_product_out          <= '0;
      error_out                 <= 1'b0;
    end else begin
      // A refill in the firing cycle keeps the slot occupied.
      if (accept) begin
        issue_q     <= issue_d;
        issue_valid <= 1'b1;
        last_grant  <= grant_id;
      end else if (mul_fire) begin
        issue_valid <= 1'b0;
      end

      resp_valid_out <= '0;
      if (tag_pop) begin
        resp_valid_out            <= N'(1) << tag_head;
        resp_product_sign_bit_out <= mul_product_sign_bit_in;
        resp_product_out          <= mul_product_in;
      end else if (mul_is_valid_in && fifo_count == '0) begin
        error_out <= 1'b1;
      end
    end
  end

`ifdef MULTIPLIER_ARBITER_STATS_EN
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      stat_issued_out <= '0;
      stat_stall_out  <= '0;
    end else begin
      if (mul_fire && stat_issued_out != '1) stat_issued_out <= stat_issued_out + 1'b1;
      if (|req_valid_in && !accept && stat_stall_out != '1) stat_stall_out <= stat_stall_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter; the bench plays the shared multiplier by hand.
module tb_multiplier_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam int P = 128;

  logic           clk = 1'b0;
  logic           reset_in;
  logic [N-1:0]   req_valid_in;
  logic [N-1:0]   req_ready_out;
  logic [N-1:0]   req_multiplier_sign_bit_in;
  logic [N*W-1:0] req_multiplier_in;
  logic [N-1:0]   req_multicand_sign_bit_in;
  logic [N*W-1:0] req_multicand_in;
  logic [N-1:0]   resp_valid_out;
  logic           resp_product_sign_bit_out;
  logic [P-1:0]   resp_product_out;
  logic           mul_is_valid_out;
  logic           mul_is_ready_in;
  logic           mul_multiplier_sign_bit_out;
  logic [W-1:0]   mul_multiplier_out;
  logic           mul_multicand_sign_bit_out;
  logic [W-1:0]   mul_multicand_out;
  logic           mul_is_valid_in;
  logic           mul_product_sign_bit_in;
  logic [P-1:0]   mul_product_in;
  logic           error_out;
`ifdef MULTIPLIER_ARBITER_STATS_EN
  logic [31:0]    stat_issued;
  logic [31:0]    stat_stall;
`endif

  always #5 clk = ~clk;

  multiplier_arbiter dut (
    .clk_in                      (clk),
    .reset_in                    (reset_in),
    .req_valid_in                (req_valid_in),
    .req_ready_out               (req_ready_out),
    .req_multiplier_sign_bit_in  (req_multiplier_sign_bit_in),
    .req_multiplier_in           (req_multiplier_in),
    .req_multicand_sign_bit_in   (req_multicand_sign_bit_in),
    .req_multicand_in            (req_multicand_in),
    .resp_valid_out              (resp_valid_out),
    .resp_product_sign_bit_out   (resp_product_sign_bit_out),
    .resp_product_out            (resp_product_out),
    .mul_is_valid_out            (mul_is_valid_out),
    .mul_is_ready_in             (mul_is_ready_in),
    .mul_multiplier_sign_bit_out (mul_multiplier_sign_bit_out),
    .mul_multiplier_out          (mul_multiplier_out),
    .mul_multicand_sign_bit_out  (mul_multicand_sign_bit_out),
    .mul_multicand_out           (mul_multicand_out),
    .mul_is_valid_in             (mul_is_valid_in),
    .mul_product_sign_bit_in     (mul_product_sign_bit_in),
    .mul_product_in              (mul_product_in),
    .error_out                   (error_out)
`ifdef MULTIPLIER_ARBITER_STATS_EN
    ,
    .stat_issued_out             (stat_issued),
    .stat_stall_out              (stat_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   rv;
    logic         mr;
    logic         mv;
    logic [127:0] prod;
    logic [3:0]   exp_ready;
    logic         exp_mvout;
    logic [63:0]  exp_mplier;
    logic [3:0]   exp_resp;
    logic [127:0] exp_prod;
    int           exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] rv, input logic mr, input logic mv, input logic [127:0] prod,
                     input logic [3:0] er, input logic emv, input logic [63:0] emul,
                     input logic [3:0] eresp, input logic [127:0] eprod, input int ecnt);
    vec_t v;
    v.rv = rv; v.mr = mr; v.mv = mv; v.prod = prod;
    v.exp_ready = er; v.exp_mvout = emv; v.exp_mplier = emul;
    v.exp_resp = eresp; v.exp_prod = eprod; v.exp_cnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      @(negedge clk);
      req_valid_in    = vecs[k].rv;
      mul_is_ready_in = vecs[k].mr;
      mul_is_valid_in = vecs[k].mv;
      mul_product_in  = vecs[k].prod;
      #1;
      check($sformatf("v%0d ready", k), req_ready_out, vecs[k].exp_ready);
      check($sformatf("v%0d mul_valid", k), mul_is_valid_out, vecs[k].exp_mvout);
      check($sformatf("v%0d resp_valid", k), resp_valid_out, vecs[k].exp_resp);
      check($sformatf("v%0d occupancy", k), dut.u_tag_fifo.count, vecs[k].exp_cnt);
      if (vecs[k].exp_resp != 4'b0000)
        check($sformatf("v%0d product", k), resp_product_out, vecs[k].exp_prod);
      if (vecs[k].exp_mvout)
        check($sformatf("v%0d issued operand", k), mul_multiplier_out, vecs[k].exp_mplier);
    end
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic sa, input logic [63:0] b, input logic sb);
    req_multiplier_in[i*W +: W]   = a;
    req_multiplier_sign_bit_in[i] = sa;
    req_multicand_in[i*W +: W]    = b;
    req_multicand_sign_bit_in[i]  = sb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_in        = 1'b1;
    req_valid_in    = '1;
    mul_is_valid_in = 1'b0;
    mul_is_ready_in = 1'b0;
    @(negedge clk);
    #1;
    check("reset ready", req_ready_out, 0);
    check("reset mul_valid", mul_is_valid_out, 0);
    check("reset resp_valid", resp_valid_out, 0);
    check("reset product", resp_product_out, 0);
    check("reset error", error_out, 0);
    check("reset operand", mul_multiplier_out, 0);
    check("reset occupancy", dut.u_tag_fifo.count, 0);
    req_valid_in = '0;
    @(negedge clk);
    reset_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset_in = 1'b1; req_valid_in = '0; mul_is_ready_in = 1'b0; mul_is_valid_in = 1'b0;
    mul_product_sign_bit_in = 1'b0; mul_product_in = '0;
    req_multiplier_in = '0; req_multicand_in = '0;
    req_multiplier_sign_bit_in = '0; req_multicand_sign_bit_in = '0;

    // Round-robin fairness, all four requesters, one-cycle multiplier.
    add(4'b1111,1,0,6762, 4'b0001,0,0,  4'b0000,0,   0);
    add(4'b1111,1,0,6762, 4'b0010,1,69, 4'b0000,0,   1);
    add(4'b1111,1,1,6762, 4'b0100,1,69, 4'b0000,0,   2);
    add(4'b1111,1,1,6762, 4'b1000,1,69, 4'b0001,6762,2);
    add(4'b1111,1,1,6762, 4'b0001,1,69, 4'b0010,6762,2);
    add(4'b0000,1,1,6762, 4'b0000,1,69, 4'b0100,6762,2);
    add(4'b0000,1,1,6762, 4'b0000,0,0,  4'b1000,6762,1);
    add(4'b0000,1,0,6762, 4'b0000,0,0,  4'b0001,6762,0);
    add(4'b0000,1,0,6762, 4'b0000,0,0,  4'b0000,0,   0);
    // FIFO full with requesters 1 and 2, then drain.
    add(4'b0110,1,0,0,     4'b0010,0,0,   4'b0000,0,    0);
    add(4'b0110,1,0,0,     4'b0100,1,123, 4'b0000,0,    1);
    add(4'b0110,1,0,0,     4'b0010,1,255, 4'b0000,0,    2);
    add(4'b0110,1,0,0,     4'b0100,1,123, 4'b0000,0,    3);
    add(4'b0110,1,0,0,     4'b0000,1,255, 4'b0000,0,    4);
    add(4'b0110,0,0,0,     4'b0000,0,0,   4'b0000,0,    4);
    add(4'b0000,0,1,15129, 4'b0000,0,0,   4'b0000,0,    4);
    add(4'b0000,0,1,24990, 4'b0000,0,0,   4'b0010,15129,3);
    add(4'b0000,0,1,15129, 4'b0000,0,0,   4'b0100,24990,2);
    add(4'b0000,0,1,24990, 4'b0000,0,0,   4'b0010,15129,1);
    add(4'b0000,0,0,0,     4'b0000,0,0,   4'b0100,24990,0);
    add(4'b0000,0,0,0,     4'b0000,0,0,   4'b0000,0,    0);
    // Push and pop in the same cycle for requester 3.
    add(4'b1000,1,0,0,      4'b1000,0,0,   4'b0000,0,     0);
    add(4'b0000,1,0,0,      4'b0000,1,999, 4'b0000,0,     1);
    add(4'b1000,1,1,988011, 4'b1000,0,0,   4'b0000,0,     1);
    add(4'b0000,1,0,0,      4'b0000,1,999, 4'b1000,988011,1);
    add(4'b0000,1,1,988011, 4'b0000,0,0,   4'b0000,0,     1);
    add(4'b0000,1,0,0,      4'b0000,0,0,   4'b1000,988011,0);

    // Single request from requester 0.
    do_reset();
    set_op(0, 64'd7, 1'b1, 64'd2, 1'b0);
    @(negedge clk); req_valid_in = 4'b0001; mul_is_ready_in = 1'b0; #1;
    check("single ready", req_ready_out, 4'b0001);
    @(negedge clk); req_valid_in = 4'b0000; mul_is_ready_in = 1'b1; #1;
    check("single mul_valid", mul_is_valid_out, 1);
    check("single multiplier", mul_multiplier_out, 7);
    check("single multiplier sign", mul_multiplier_sign_bit_out, 1);
    check("single multicand", mul_multicand_out, 2);
    check("single multicand sign", mul_multicand_sign_bit_out, 0);
    @(negedge clk); mul_is_ready_in = 1'b0; mul_is_valid_in = 1'b1;
    mul_product_in = 128'd14; mul_product_sign_bit_in = 1'b1; #1;
    check("single mul_valid drop", mul_is_valid_out, 0);
    @(negedge clk); mul_is_valid_in = 1'b0; mul_product_sign_bit_in = 1'b0; #1;
    check("single resp_valid", resp_valid_out, 4'b0001);
    check("single product", resp_product_out, 14);
    check("single product sign", resp_product_sign_bit_out, 1);
    @(negedge clk); #1;
    check("single resp one cycle", resp_valid_out, 0);

    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 64'd69, 1'b0, 64'd98, 1'b0);
    run_vecs(0, 8);
    set_op(1, 64'd123, 1'b0, 64'd123, 1'b0);
    set_op(2, 64'd255, 1'b0, 64'd98, 1'b0);
    run_vecs(9, 20);
    set_op(3, 64'd999, 1'b0, 64'd989, 1'b0);
    run_vecs(21, 26);

    // Spurious product with nothing outstanding.
    @(negedge clk); req_valid_in = '0; mul_is_valid_in = 1'b1; mul_product_in = 128'd5; #1;
    @(negedge clk); mul_is_valid_in = 1'b0; #1;
    check("spurious resp_valid", resp_valid_out, 0);
    check("spurious error", error_out, 1);
    repeat (3) @(negedge clk);
    #1;
    check("spurious error sticky", error_out, 1);

    // Reset with three operations outstanding.
    mul_is_ready_in = 1'b1;
    @(negedge clk); req_valid_in = 4'b0111; #1;
    check("preload grant 0", req_ready_out, 4'b0001);
    @(negedge clk); #1;
    check("preload grant 1", req_ready_out, 4'b0010);
    @(negedge clk); #1;
    check("preload grant 2", req_ready_out, 4'b0100);
    @(negedge clk); req_valid_in = '0; #1;
    check("preload occupancy", dut.u_tag_fifo.count, 3);
    do_reset();
    @(negedge clk); req_valid_in = 4'b1111; #1;
    check("post-reset priority", req_ready_out, 4'b0001);
    @(negedge clk); req_valid_in = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
